alu_exec_unit: RTL and testbench

//  Multi-cycle ALU execution unit. It consumes the 4-bit ALU control code that the ALU-op decoder

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_shift_iter.sv | 62 ++++++
 rtl/alu_exec_unit.sv | 132 +++++++++++++
 tb/tb_alu_exec_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control code table and execution-unit FSM encoding
// Purpose: one code table shared by the ALU-op decoder and alu_exec_unit.
// Contents: ALU_* 4-bit control codes, alu_state_e FSM states, alu_is_shift().
package alu_pkg;

  localparam logic [3:0] ALU_ADD     = 4'b0000;
  localparam logic [3:0] ALU_SUB     = 4'b0001;
  localparam logic [3:0] ALU_SLL     = 4'b0010;
  localparam logic [3:0] ALU_SLT     = 4'b0011;
  localparam logic [3:0] ALU_SLTU    = 4'b0100;
  localparam logic [3:0] ALU_XOR     = 4'b0101;
  localparam logic [3:0] ALU_SRL     = 4'b0110;
  localparam logic [3:0] ALU_SRA     = 4'b0111;
  localparam logic [3:0] ALU_OR      = 4'b1000;
  localparam logic [3:0] ALU_AND     = 4'b1001;
  localparam logic [3:0] ALU_SGE     = 4'b1011;
  localparam logic [3:0] ALU_SGEU    = 4'b1100;
  localparam logic [3:0] ALU_INVALID = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic alu_is_shift(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// rtl/alu_shift_iter.sv - iterative 1-bit-per-cycle shifter with down-counter
// Purpose: holds the operand being shifted and the remaining shift count.
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset
//   load           capture value_in/shamt/dir/arith (start of a shift op)
//   en             perform one shift step this cycle (while count is nonzero)
//   dir            0 = left, 1 = right
//   arith          right shifts fill with the msb instead of 0
//   value_in       operand to shift
//   shamt          number of 1-bit steps
//   value          register contents after one more step (the next value)
//   done           the pending step is the last one (count == 1)
module alu_shift_iter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load,
  input  logic               en,
  input  logic               dir,
  input  logic               arith,
  input  logic [WIDTH-1:0]   value_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   value,
  output logic               done
);

  logic [WIDTH-1:0]   sreg_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               dir_q;
  logic               arith_q;

  // Direction and fill mode are latched at load so the caller's op may change.
  always_comb begin
    value = sreg_q;
    if (dir_q) begin
      value = {arith_q & sreg_q[WIDTH-1], sreg_q[WIDTH-1:1]};
    end else begin
      value = {sreg_q[WIDTH-2:0], 1'b0};
    end
    done = (cnt_q == SHAMT_W'(1));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sreg_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else if (load) begin
      sreg_q  <= value_in;
      cnt_q   <= shamt;
      dir_q   <= dir;
      arith_q <= arith;
    end else if (en && (cnt_q != '0)) begin
      sreg_q  <= value;
      cnt_q   <= cnt_q - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - multi-cycle ALU execution unit (IDLE/SHIFT/DONE)
// Purpose: executes one ALU control code on two operands; single-cycle ops
//   finish in one cycle, shifts iterate one bit per cycle.
// Ports:
//   clk_i, rst_ni         clock, synchronous active-low reset
//   valid_i, ready_o      operation handshake (ready_o only in IDLE)
//   op_i, a_i, b_i        control code and operands, captured at accept
//   valid_o, ready_i      result handshake (valid_o only in DONE)
//   result_o              registered result
//   zero_o                result_o == 0
//   illegal_o             op_i was not a defined code
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             illegal_o
);

  localparam int SHAMT_W = $clog2(WIDTH);

  alu_state_e         state_q, state_d;
  logic               accept;
  logic               shift_load;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_illegal;
  logic [WIDTH-1:0]   shift_value;
  logic               shift_done;
  logic               shift_en;

  assign shamt      = b_i[SHAMT_W-1:0];
  assign accept     = valid_i && ready_o;
  // Zero-distance shifts take the single-cycle path and return a_i unchanged.
  assign shift_load = accept && alu_is_shift(op_i) && (shamt != '0);
  assign shift_en   = (state_q == ST_SHIFT);

  // Single-cycle datapath.
  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    case (op_i)
      ALU_ADD:  alu_res = a_i + b_i;
      ALU_SUB:  alu_res = a_i - b_i;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  alu_res = a_i;
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      ALU_XOR:  alu_res = a_i ^ b_i;
      ALU_OR:   alu_res = a_i | b_i;
      ALU_AND:  alu_res = a_i & b_i;
      ALU_SGE:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_i) >= $signed(b_i))};
      ALU_SGEU: alu_res = {{(WIDTH-1){1'b0}}, (a_i >= b_i)};
      default:  alu_illegal = 1'b1;
    endcase
  end

  alu_shift_iter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shift (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load     (shift_load),
    .en       (shift_en),
    .dir      (op_i != ALU_SLL),
    .arith    (op_i == ALU_SRA),
    .value_in (a_i),
    .shamt    (shamt),
    .value    (shift_value),
    .done     (shift_done)
  );

  // Next-state and handshake outputs.
  always_comb begin
    state_d = state_q;
    ready_o = rst_ni && (state_q == ST_IDLE);
    valid_o = (state_q == ST_DONE);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = shift_load ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (shift_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      result_o  <= '0;
      zero_o    <= 1'b0;
      illegal_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && !shift_load) begin
        result_o  <= alu_res;
        zero_o    <= (alu_res == '0);
        illegal_o <= alu_illegal;
      end else if (shift_en && shift_done) begin
        // The last step's value is written directly, saving a cycle.
        result_o  <= shift_value;
        zero_o    <= (shift_value == '0);
        illegal_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic [3:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        zero_o;
  logic        illegal_o;

  int passed = 0;
  int total  = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .op_i      (op_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .result_o  (result_o),
    .zero_o    (zero_o),
    .illegal_o (illegal_o)
  );

  always #5 clk_i = ~clk_i;

  // Issues one op (called #1 after an edge), scrambles inputs after accept,
  // waits for valid_o, returns latency in edges counting the accept edge.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic z, output logic ill);
    valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk_i); #1;
    valid_i = 1'b0; op_i = 4'($urandom); a_i = $urandom; b_i = $urandom;
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(posedge clk_i); #1;
      lat++;
    end
    res = result_o; z = zero_o; ill = illegal_o;
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b1; op_i = '0; a_i = '0; b_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    total++; if (ready_o !== 1'b0) $display("FAIL reset_ready got %0b exp 0", ready_o); else passed++;
    total++; if (valid_o !== 1'b0) $display("FAIL reset_valid got %0b exp 0", valid_o); else passed++;
    total++; if ({result_o, zero_o, illegal_o} !== 34'd0)
      $display("FAIL reset_outputs got %h/%b/%b exp 0/0/0", result_o, zero_o, illegal_o); else passed++;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    total++; if (ready_o !== 1'b1) $display("FAIL reset_release_ready got %0b exp 1", ready_o); else passed++;
  endtask

  // Vector table: op, a, b, expected result, zero, latency.
  task automatic test_vectors(input string name, input logic [3:0] ops[], input logic [31:0] as[],
                              input logic [31:0] bs[], input logic [31:0] exps[], input int lats[]);
    int lat; logic [31:0] res; logic z, ill;
    foreach (ops[i]) begin
      run_op(ops[i], as[i], bs[i], lat, res, z, ill);
      total++; if (res !== exps[i]) $display("FAIL %s[%0d]_result got %h exp %h", name, i, res, exps[i]); else passed++;
      total++; if (z !== (exps[i] == 32'd0)) $display("FAIL %s[%0d]_zero got %b exp %b", name, i, z, exps[i] == 32'd0); else passed++;
      total++; if (ill !== 1'b0) $display("FAIL %s[%0d]_illegal got %b exp 0", name, i, ill); else passed++;
      total++; if (lat !== lats[i]) $display("FAIL %s[%0d]_latency got %0d exp %0d", name, i, lat, lats[i]); else passed++;
    end
  endtask

  task automatic test_arith();
    test_vectors("arith",
      '{4'b0000, 4'b0001, 4'b0101, 4'b0001, 4'b1000, 4'b1001},
      '{32'hFFFF_FFFF, 32'd5, 32'd7, 32'd3, 32'h0000_00F0, 32'h0000_00F0},
      '{32'd1, 32'd5, 32'd3, 32'd5, 32'h0000_000F, 32'h0000_003C},
      '{32'd0, 32'd0, 32'd4, 32'hFFFF_FFFE, 32'h0000_00FF, 32'h0000_0030},
      '{1, 1, 1, 1, 1, 1});
  endtask

  task automatic test_compare();
    test_vectors("cmp",
      '{4'b0011, 4'b0100, 4'b1011, 4'b1100, 4'b1011, 4'b1100},
      '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd2},
      '{32'd1, 32'd1, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd2},
      '{32'd1, 32'd0, 32'd1, 32'd0, 32'd0, 32'd1},
      '{1, 1, 1, 1, 1, 1});
  endtask

  task automatic test_shift();
    test_vectors("shift",
      '{4'b0111, 4'b0010, 4'b0110, 4'b0010, 4'b0010, 4'b0111, 4'b0110},
      '{32'h8000_0000, 32'h0000_1234, 32'h8000_0000, 32'd1, 32'd3, 32'h4000_0000, 32'h0000_0001},
      '{32'd31, 32'd0, 32'd4, 32'd31, 32'h0000_0021, 32'd2, 32'd1},
      '{32'hFFFF_FFFF, 32'h0000_1234, 32'h0800_0000, 32'h8000_0000, 32'd6, 32'h1000_0000, 32'd0},
      '{32, 1, 5, 32, 2, 3, 2});
  endtask

  task automatic test_illegal_hold();
    int lat; logic [31:0] res; logic z, ill;
    logic [3:0] bad[3] = '{4'b1010, 4'b1110, 4'b1111};
    run_op(4'b0000, 32'd2, 32'd3, lat, res, z, ill);
    foreach (bad[i]) begin
      run_op(bad[i], 32'h1234_5678, 32'h0000_0042, lat, res, z, ill);
      total++; if (res !== 32'd0) $display("FAIL illegal[%0d]_result got %h exp 0", i, res); else passed++;
      total++; if (ill !== 1'b1) $display("FAIL illegal[%0d]_flag got %b exp 1", i, ill); else passed++;
      total++; if (lat !== 1) $display("FAIL illegal[%0d]_latency got %0d exp 1", i, lat); else passed++;
    end
    // Stall the consumer on an illegal result and offer a new op meanwhile.
    ready_i = 1'b0;
    run_op(4'b1110, 32'd9, 32'd9, lat, res, z, ill);
    valid_i = 1'b1; op_i = 4'b0000; a_i = 32'd1; b_i = 32'd1;
    for (int c = 0; c < 5; c++) begin
      total++;
      if ({valid_o, ready_o, result_o, illegal_o} !== {1'b1, 1'b0, 32'd0, 1'b1})
        $display("FAIL hold[%0d] got v=%b r=%b res=%h ill=%b exp v=1 r=0 res=0 ill=1",
                 c, valid_o, ready_o, result_o, illegal_o);
      else passed++;
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0; ready_i = 1'b1;
    @(posedge clk_i); #1;
    total++; if ({valid_o, ready_o} !== 2'b01) $display("FAIL hold_release got v=%b r=%b exp v=0 r=1", valid_o, ready_o); else passed++;
    @(posedge clk_i); #1;
    total++; if (valid_o !== 1'b0) $display("FAIL hold_no_ghost got v=%b exp 0", valid_o); else passed++;
  endtask

  task automatic test_reset_mid_shift();
    int lat; int seen; logic [31:0] res; logic z, ill;
    run_op(4'b0000, 32'd3, 32'd4, lat, res, z, ill);
    total++; if (res !== 32'd7) $display("FAIL pre_reset_add got %h exp 7", res); else passed++;
    valid_i = 1'b1; op_i = 4'b0110; a_i = 32'hFFFF_0000; b_i = 32'd20;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    total++; if ({ready_o, valid_o, result_o, zero_o, illegal_o} !== 36'd0)
      $display("FAIL midreset got r=%b v=%b res=%h z=%b ill=%b exp all 0",
               ready_o, valid_o, result_o, zero_o, illegal_o); else passed++;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    total++; if (ready_o !== 1'b1) $display("FAIL midreset_ready got %b exp 1", ready_o); else passed++;
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      if (valid_o) seen++;
      @(posedge clk_i); #1;
    end
    total++; if (seen !== 0) $display("FAIL midreset_no_valid got %0d valid cycles exp 0", seen); else passed++;
    total++; if (result_o !== 32'd0) $display("FAIL midreset_result got %h exp 0", result_o); else passed++;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_compare();
    test_shift();
    test_illegal_hold();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
